// File: rtl/prog_mem_arbiter.sv
// Run-state sequencer and single-port memory arbiter between the switch loader and the CPU.
// Grants are registered; the memory mux follows the grant registers combinationally.
module prog_mem_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STARVE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              loadMode,
  input  logic              ldReq,
  input  logic              ldWe,
  input  logic [ADDR_W-1:0] ldAddr,
  input  logic [DATA_W-1:0] ldData,
  output logic              ldGnt,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuData,
  output logic              cpuGnt,
  input  logic              cpuHalt,
  output logic              cpuRun,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic              memWe,
  output logic [1:0]        mode
);

  localparam int unsigned CntW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {
    StLoad    = 2'b00,
    StRun     = 2'b01,
    StHalt    = 2'b10,
    StRestart = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic              ld_gnt_q, ld_gnt_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              cpu_want;
  logic              starved;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StLoad;
      ld_gnt_q  <= 1'b0;
      cpu_gnt_q <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      ld_gnt_q  <= ld_gnt_d;
      cpu_gnt_q <= cpu_gnt_d;
      starve_q  <= starve_d;
    end
  end

  // A halting CPU gets no grant at the edge that moves us to HALT.
  assign cpu_want = cpuReq && !cpuHalt;
  assign starved  = (starve_q == CntW'(STARVE));

  always_comb begin
    state_d   = state_q;
    ld_gnt_d  = 1'b0;
    cpu_gnt_d = 1'b0;
    starve_d  = '0;
    unique case (state_q)
      StLoad: begin
        ld_gnt_d = ldReq;
        if (start) state_d = StRun;
      end
      StRun: begin
        ld_gnt_d  = ldReq && (!cpu_want || starved);
        cpu_gnt_d = cpu_want && !ld_gnt_d;
        if (cpuHalt) begin
          state_d = StHalt;
        end else if (ld_gnt_d) begin
          starve_d = '0;
        end else if (ldReq) begin
          starve_d = starve_q + 1'b1;
        end else begin
          starve_d = starve_q;
        end
      end
      StHalt: begin
        ld_gnt_d = ldReq;
        if (start) begin
          state_d = StRestart;
        end else if (loadMode) begin
          state_d = StLoad;
        end
      end
      StRestart: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    memAddr = '0;
    memDin  = '0;
    memWe   = 1'b0;
    if (ld_gnt_q) begin
      memAddr = ldAddr;
      memDin  = ldData;
      memWe   = ldWe;
    end else if (cpu_gnt_q) begin
      memAddr = cpuAddr;
      memDin  = cpuData;
      memWe   = cpuWe;
    end
  end

  assign ldGnt  = ld_gnt_q;
  assign cpuGnt = cpu_gnt_q;
  assign cpuRun = (state_q == StRun) || (state_q == StHalt);
  assign mode   = state_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: directed vector table, hand sequences for starvation and
// asynchronous reset, then random stimulus against a behavioural model.
module tb_prog_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, loadMode = 1'b0;
  logic       ldReq = 1'b0, ldWe = 1'b0;
  logic [4:0] ldAddr = '0;
  logic [7:0] ldData = '0;
  logic       ldGnt;
  logic       cpuReq = 1'b0, cpuWe = 1'b0;
  logic [4:0] cpuAddr = '0;
  logic [7:0] cpuData = '0;
  logic       cpuGnt;
  logic       cpuHalt = 1'b0;
  logic       cpuRun;
  logic [4:0] memAddr;
  logic [7:0] memDin;
  logic       memWe;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fails  = 0;

  prog_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .STARVE(4)) dut (
    .clock(clock), .reset(reset), .start(start), .loadMode(loadMode),
    .ldReq(ldReq), .ldWe(ldWe), .ldAddr(ldAddr), .ldData(ldData), .ldGnt(ldGnt),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuData(cpuData), .cpuGnt(cpuGnt),
    .cpuHalt(cpuHalt), .cpuRun(cpuRun), .memAddr(memAddr), .memDin(memDin), .memWe(memWe),
    .mode(mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, st, lm, lr, lw;
    logic [4:0] la;
    logic [7:0] ld;
    logic       cr, cw;
    logic [4:0] ca;
    logic [7:0] cd;
    logic       h;
    logic       e_ld, e_cpu, e_run;
    logic [4:0] e_addr;
    logic [7:0] e_din;
    logic       e_we;
    logic [1:0] e_mode;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, logic lm, logic lr, logic lw,
                              logic [4:0] la, logic [7:0] ld, logic cr, logic cw,
                              logic [4:0] ca, logic [7:0] cd, logic h,
                              logic e_ld, logic e_cpu, logic e_run, logic [4:0] e_addr,
                              logic [7:0] e_din, logic e_we, logic [1:0] e_mode);
    vec_t v;
    v.rst = rst; v.st = st; v.lm = lm; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.h = h;
    v.e_ld = e_ld; v.e_cpu = e_cpu; v.e_run = e_run; v.e_addr = e_addr;
    v.e_din = e_din; v.e_we = e_we; v.e_mode = e_mode;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ld, input logic e_cpu,
                           input logic e_run, input logic [4:0] e_addr, input logic [7:0] e_din,
                           input logic e_we, input logic [1:0] e_mode);
    check({tag, ".ldGnt"}, 32'(ldGnt), 32'(e_ld));
    check({tag, ".cpuGnt"}, 32'(cpuGnt), 32'(e_cpu));
    check({tag, ".cpuRun"}, 32'(cpuRun), 32'(e_run));
    check({tag, ".memAddr"}, 32'(memAddr), 32'(e_addr));
    check({tag, ".memDin"}, 32'(memDin), 32'(e_din));
    check({tag, ".memWe"}, 32'(memWe), 32'(e_we));
    check({tag, ".mode"}, 32'(mode), 32'(e_mode));
  endtask

  task automatic idle_inputs();
    start = 0; loadMode = 0; ldReq = 0; ldWe = 0; ldAddr = 0; ldData = 0;
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuData = 0; cpuHalt = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    next_cycle();
    reset = 0;
  endtask

  vec_t vecs[$];

  // Behavioural model state: mode number, starvation count, pending grants.
  int m_mode, m_starve;
  bit m_ld, m_cpu;

  initial begin
    // Directed table: inputs held for one cycle, outputs checked mid-cycle.
    vecs.push_back(mk(1,0,0, 0,0, 0,8'h00, 0,0, 0,8'h00, 0,  0,0,0, 0,8'h00,0, 0));
    vecs.push_back(mk(0,0,0, 1,1, 3,8'hA5, 1,1, 9,8'h11, 0,  0,0,0, 0,8'h00,0, 0));
    vecs.push_back(mk(0,0,0, 0,1, 3,8'hA5, 1,1, 9,8'h11, 0,  1,0,0, 3,8'hA5,1, 0));
    vecs.push_back(mk(0,1,0, 0,0, 0,8'h00, 1,1, 9,8'h11, 0,  0,0,0, 0,8'h00,0, 0));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 1,0, 7,8'h22, 0,  0,0,1, 0,8'h00,0, 1));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 0,0, 7,8'h22, 0,  0,1,1, 7,8'h22,0, 1));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 0,0, 0,8'h00, 1,  0,0,1, 0,8'h00,0, 1));
    vecs.push_back(mk(0,0,0, 1,0,12,8'h00, 1,0, 4,8'h00, 1,  0,0,1, 0,8'h00,0, 2));
    vecs.push_back(mk(0,0,0, 0,0,12,8'h00, 1,0, 4,8'h00, 1,  1,0,1,12,8'h00,0, 2));
    vecs.push_back(mk(0,1,1, 0,0, 0,8'h00, 1,0, 4,8'h00, 0,  0,0,1, 0,8'h00,0, 2));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 1,0, 4,8'h00, 0,  0,0,0, 0,8'h00,0, 3));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 1,0, 4,8'h00, 0,  0,0,1, 0,8'h00,0, 1));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 0,0, 4,8'h33, 1,  0,1,1, 4,8'h33,0, 1));
    vecs.push_back(mk(0,0,1, 0,0, 0,8'h00, 0,0, 0,8'h00, 0,  0,0,1, 0,8'h00,0, 2));
    vecs.push_back(mk(0,0,0, 1,1,31,8'h5A, 1,0, 0,8'h00, 0,  0,0,0, 0,8'h00,0, 0));
    vecs.push_back(mk(0,0,0, 1,1,31,8'h5A, 1,0, 0,8'h00, 0,  1,0,0,31,8'h5A,1, 0));
    vecs.push_back(mk(0,0,0, 0,1,31,8'h5A, 0,0, 0,8'h00, 0,  1,0,0,31,8'h5A,1, 0));
    vecs.push_back(mk(0,0,0, 0,0, 0,8'h00, 0,0, 0,8'h00, 0,  0,0,0, 0,8'h00,0, 0));

    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; loadMode = vecs[i].lm;
      ldReq = vecs[i].lr; ldWe = vecs[i].lw; ldAddr = vecs[i].la; ldData = vecs[i].ld;
      cpuReq = vecs[i].cr; cpuWe = vecs[i].cw; cpuAddr = vecs[i].ca; cpuData = vecs[i].cd;
      cpuHalt = vecs[i].h;
      @(negedge clock);
      check_all($sformatf("vec%0d", i), vecs[i].e_ld, vecs[i].e_cpu, vecs[i].e_run,
                vecs[i].e_addr, vecs[i].e_din, vecs[i].e_we, vecs[i].e_mode);
      next_cycle();
    end

    // Starvation: both requesters held in RUN -> four CPU grants, then one loader grant.
    do_reset();
    start = 1;
    next_cycle();
    start = 0; cpuReq = 1; ldReq = 1; ldAddr = 2; cpuAddr = 6;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i > 0) begin
        check($sformatf("starve%0d.ldGnt", i), 32'(ldGnt), 32'(i % 5 == 0));
        check($sformatf("starve%0d.cpuGnt", i), 32'(cpuGnt), 32'(i % 5 != 0));
        check($sformatf("starve%0d.memAddr", i), 32'(memAddr), (i % 5 == 0) ? 32'd2 : 32'd6);
      end
      next_cycle();
    end

    // Asynchronous reset in the middle of a loader write grant while running.
    do_reset();
    start = 1;
    next_cycle();
    start = 0; ldReq = 1; ldWe = 1; ldAddr = 5; ldData = 8'h3C;
    next_cycle();
    ldReq = 0;
    @(negedge clock);
    check_all("pre_rst", 1, 0, 1, 5, 8'h3C, 1, 1);
    #1 reset = 1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 8'h00, 0, 0);
    next_cycle();
    reset = 0;
    idle_inputs();

    // Random stimulus against the model.
    do_reset();
    m_mode = 0; m_starve = 0; m_ld = 0; m_cpu = 0;
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(7) == 0);
      loadMode = ($urandom_range(7) == 0);
      cpuHalt  = ($urandom_range(5) == 0);
      ldReq    = $urandom_range(1);
      cpuReq   = ($urandom_range(3) != 0);
      ldWe     = $urandom_range(1);
      cpuWe    = $urandom_range(1);
      ldAddr   = 5'($urandom);
      cpuAddr  = 5'($urandom);
      ldData   = 8'($urandom);
      cpuData  = 8'($urandom);
      @(negedge clock);
      check_all($sformatf("rnd%0d", c), m_ld, m_cpu, (m_mode == 1 || m_mode == 2),
                m_ld ? ldAddr : (m_cpu ? cpuAddr : 5'd0),
                m_ld ? ldData : (m_cpu ? cpuData : 8'd0),
                m_ld ? ldWe : (m_cpu ? cpuWe : 1'b0), 2'(m_mode));
      begin
        bit cpu_wins_normally, ld_next, cpu_next;
        int mode_next;
        cpu_wins_normally = (m_mode == 1) && cpuReq && !cpuHalt;
        ld_next = ldReq && (m_mode == 0 || m_mode == 2 ||
                            (m_mode == 1 && (!cpu_wins_normally || m_starve >= 4)));
        cpu_next = cpu_wins_normally && !ld_next;
        if (m_mode == 1 && !cpuHalt) begin
          if (ld_next) m_starve = 0;
          else if (ldReq && m_starve < 4) m_starve = m_starve + 1;
        end else begin
          m_starve = 0;
        end
        mode_next = m_mode;
        if (m_mode == 0 && start) mode_next = 1;
        if (m_mode == 1 && cpuHalt) mode_next = 2;
        if (m_mode == 2) mode_next = start ? 3 : (loadMode ? 0 : 2);
        if (m_mode == 3) mode_next = 1;
        m_mode = mode_next;
        m_ld = ld_next;
        m_cpu = cpu_next;
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Sequencer and arbiter for the processor's single-port 32x8 program/data memory. Shares the memory between a switch-driven program loader and the CPU, and controls CPU run state: holds the CPU in reset while a program is loaded, releases it on start, and detects halt. Sits between the board I/O (switches/keys) and the CPU top level.

## Interface
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 8, memory word width
- STARVE, 4, consecutive denied loader-request cycles in RUN before the loader is forced to win

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  synchronous one-cycle pulse; begin or restart execution
- loadMode  in  1  synchronous one-cycle pulse; return to LOAD from HALT
- ldReq  in  1  loader access request; held until ldGnt
- ldWe  in  1  loader write (1) / read (0)
- ldAddr  in  ADDR_W  loader address
- ldData  in  DATA_W  loader write data
- ldGnt  out  1  one-cycle grant to loader
- cpuReq  in  1  CPU access request; held until cpuGnt
- cpuWe  in  1  CPU write/read
- cpuAddr  in  ADDR_W  CPU address
- cpuData  in  DATA_W  CPU write data
- cpuGnt  out  1  one-cycle grant to CPU
- cpuHalt  in  1  CPU Halt flag
- cpuRun  out  1  0 holds CPU in reset
- memAddr  out  ADDR_W  memory address
- memDin  out  DATA_W  memory write data
- memWe  out  1  memory write enable
- mode  out  2  state for LEDs: 00 LOAD, 01 RUN, 10 HALT, 11 RESTART

## Operation
- States: LOAD (reset state), RUN, HALT, RESTART.
- LOAD: cpuRun=0; only loader may be granted; cpuReq ignored. start -> RUN.
- RUN: cpuRun=1. CPU has priority. Loader granted only if cpuReq=0, or if starvation counter has reached STARVE. cpuHalt=1 -> HALT.
- HALT: cpuRun=1 (CPU state frozen by its own Halt; output visible); loader granted freely; CPU not granted. start -> RESTART; loadMode -> LOAD.
- RESTART: cpuRun=0 for exactly one cycle, no grants, then -> RUN.
- start and loadMode in any other state: ignored. Simultaneous start and loadMode in HALT: start wins.
- Starvation counter: counts RUN cycles with ldReq=1 and ldGnt not issued; saturates at STARVE; cleared on ldGnt, on leaving RUN, and on reset. Forced loader win denies the CPU that cycle.
- Memory mux: when ldGnt=1, mem* = ldAddr/ldData/ldWe; when cpuGnt=1, mem* = cpuAddr/cpuData/cpuWe; otherwise memAddr=0, memDin=0, memWe=0. ldGnt and cpuGnt never high together.
- Read data returns directly from memory to requesters (not through this block).

## Timing
- Reset (async) values: state LOAD, mode=00, cpuRun=0, ldGnt=0, cpuGnt=0, memWe=0, memAddr=0, memDin=0, starvation counter 0.
- Grants registered: request sampled at edge N, grant high during cycle N+1 for one cycle; memory access occurs in the grant cycle using requester's held address/data (mux combinational from grant).
- Requester still asserting req in grant cycle is re-arbitrated at that edge; back-to-back grants to the same requester are allowed (one access per cycle max).
- State transitions take effect at the edge sampling the trigger; grants for the new state start the following cycle. A grant already issued completes in its cycle regardless of transition.
- cpuHalt sampled every RUN cycle; HALT entered on the next edge; no CPU grant issued from that edge onward.
- Reset mid-access: grant and memWe drop immediately (asynchronous).

## Test plan
- Reset, ldReq=1 ldWe=1 ldAddr=3 ldData=0xA5 in LOAD -> ldGnt one cycle later, memWe=1, memAddr=3, memDin=0xA5; cpuReq=1 simultaneously never granted; cpuRun=0.
- start pulse -> mode=01, cpuRun=1 next cycle; cpuReq read of addr 7 -> cpuGnt after one cycle, memWe=0, memAddr=7.
- RUN, cpuReq and ldReq held high continuously -> CPU granted 4 consecutive times, then ldGnt once, counter cleared, pattern repeats.
- RUN, cpuHalt=1 -> mode=10 next edge; subsequent cpuReq unanswered; ldReq read granted.
- HALT, start pulse -> mode=11 with cpuRun=0 for exactly one cycle, then mode=01, cpuRun=1; HALT with start and loadMode together -> RESTART.
- Assert reset during a loader write grant -> ldGnt and memWe low immediately, mode=00, cpuRun=0.
